// File: rtl/gc_row_scheduler.sv
// Row-select sequencer for the gain-cell 3:8 decoder: host access vs. refresh.
// Optional REF_OVERRUN_EN adds ref_overrun / ref_overrun_cnt outputs.
module gc_row_scheduler #(
    parameter int ROW_W            = 3,
    parameter int REFRESH_INTERVAL = 64,
    parameter int ACCESS_CYCLES    = 2,
    parameter int PRECHARGE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ROW_W-1:0] req_row,
    output logic             wl_en,
    output logic [ROW_W-1:0] wl_sel,
    output logic             wl_we,
    output logic             ref_active,
    output logic             done,
    output logic [ROW_W-1:0] ref_ptr
`ifdef REF_OVERRUN_EN
    ,
    output logic             ref_overrun,
    output logic [7:0]       ref_overrun_cnt
`endif
);

    localparam int CNT_W  = $clog2(REFRESH_INTERVAL);
    localparam int PH_MAX = (ACCESS_CYCLES > PRECHARGE_CYCLES) ?
                            ACCESS_CYCLES : PRECHARGE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        PRECHARGE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [PH_W-1:0]   ph;
    logic              ref_pend;
    logic              pend_n;
    logic              expire;
    logic              service;
    logic              accept;
    logic              ph_zero;
    logic              pre_last_n;

    assign expire  = (cnt == '0);
    assign service = (state == IDLE) && ref_pend;
    assign accept  = (state == IDLE) && !ref_pend && req_valid && req_ready;
    assign ph_zero = (ph == '0);
    assign pend_n  = expire | (ref_pend & ~service);

    // pre_last_n: the cycle entered at this edge is the final precharge cycle
    always_comb begin
        state_n    = state;
        pre_last_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (service || accept) state_n = ACTIVE;
            end
            ACTIVE: begin
                if (ph_zero) begin
                    state_n    = PRECHARGE;
                    pre_last_n = (PRECHARGE_CYCLES == 1);
                end
            end
            PRECHARGE: begin
                if (ph_zero) state_n = IDLE;
                else         pre_last_n = (ph == PH_W'(1));
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= CNT_W'(REFRESH_INTERVAL - 1);
            ph         <= '0;
            ref_pend   <= 1'b0;
            ref_ptr    <= '0;
            req_ready  <= 1'b0;
            wl_en      <= 1'b0;
            wl_sel     <= '0;
            wl_we      <= 1'b0;
            ref_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            cnt       <= expire ? CNT_W'(REFRESH_INTERVAL - 1) : cnt - CNT_W'(1);
            ref_pend  <= pend_n;
            state     <= state_n;
            req_ready <= (state_n == IDLE) && !pend_n;
            done      <= pre_last_n && !ref_active;
            if (pre_last_n && ref_active) ref_ptr <= ref_ptr + ROW_W'(1);
            unique case (state)
                IDLE: begin
                    if (service) begin
                        wl_en      <= 1'b1;
                        wl_sel     <= ref_ptr;
                        wl_we      <= 1'b0;
                        ref_active <= 1'b1;
                        ph         <= PH_W'(ACCESS_CYCLES - 1);
                    end else if (accept) begin
                        wl_en  <= 1'b1;
                        wl_sel <= req_row;
                        wl_we  <= req_we;
                        ph     <= PH_W'(ACCESS_CYCLES - 1);
                    end
                end
                ACTIVE: begin
                    if (ph_zero) begin
                        wl_en <= 1'b0;
                        wl_we <= 1'b0;
                        ph    <= PH_W'(PRECHARGE_CYCLES - 1);
                    end else begin
                        ph <= ph - PH_W'(1);
                    end
                end
                PRECHARGE: begin
                    if (ph_zero) ref_active <= 1'b0;
                    else         ph <= ph - PH_W'(1);
                end
                default: begin
                    wl_en <= 1'b0;
                    wl_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef REF_OVERRUN_EN
    // An expiry landing on a still-pending refresh is lost; record it
    logic overrun;
    assign overrun = expire & ref_pend & ~service;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_overrun     <= 1'b0;
            ref_overrun_cnt <= '0;
        end else begin
            ref_overrun <= overrun;
            if (overrun && ref_overrun_cnt != 8'hff)
                ref_overrun_cnt <= ref_overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
